// File: rtl/led_palette_fader_pkg.sv
// led_palette_pkg: shared types, group offsets and helpers for the palette fader
package led_palette_pkg;
  typedef enum logic {ST_IDLE, ST_SCAN} t_fader_state;
  localparam int c_grp_red = 0;
  localparam int c_grp_green = 1;
  localparam int c_grp_blue = 2;
  localparam int c_grp_basic = 3;
  function automatic int fn_tick_cycles(input longint fclk, input longint us);
    return int'(fclk / 1_000_000 * us);
  endfunction
  function automatic int fn_group_base(input int grp, input int c);
    return grp * c;
  endfunction
  // Move cur toward tgt by at most step, never past tgt and never wrapping.
  function automatic logic [7:0] fn_slew(input logic [7:0] cur, input logic [7:0] tgt,
                                         input logic [7:0] step);
    logic [8:0] d;
    logic [8:0] mag;
    d = {1'b0, tgt} - {1'b0, cur};
    mag = d[8] ? -d : d;
    mag = (mag > {1'b0, step}) ? {1'b0, step} : mag;
    return d[8] ? cur - mag[7:0] : cur + mag[7:0];
  endfunction
endpackage

// File: rtl/led_step_tick_gen.sv
// led_step_tick_gen: free-running down-counter producing a 1-cycle tick every parm_cycles clocks
module led_step_tick_gen #(
  parameter int parm_cycles = 40
) (
  input  logic i_clk,
  input  logic i_arstn,
  output logic o_tick
);
  localparam int c_w = ($clog2(parm_cycles) > 0) ? $clog2(parm_cycles) : 1;
  localparam logic [c_w-1:0] c_reload = c_w'(parm_cycles - 1);
  logic [c_w-1:0] r_count;
  logic w_tick;
  assign w_tick = r_count == '0;
  assign o_tick = w_tick;
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) r_count <= c_reload;
    else r_count <= w_tick ? c_reload : r_count - c_w'(1);
endmodule

// File: rtl/led_palette_fader.sv
// led_palette_fader: per-channel palette targets slewed toward by a periodic one-channel-per-cycle scan
module led_palette_fader
  import led_palette_pkg::*;
#(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK = 40_000_000,
  parameter int parm_step_period_microseconds = 1000,
  parameter int parm_step_size = 1
) (
  input  logic i_clk,
  input  logic i_arstn,
  input  logic i_cmd_valid,
  output logic o_cmd_ready,
  input  logic [$clog2(3*parm_color_led_count+parm_basic_led_count+1)-1:0] i_cmd_index,
  input  logic [7:0] i_cmd_target,
  input  logic i_cmd_immediate,
  output logic o_cmd_error,
  output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
  output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
  output logic o_all_settled
);
  localparam int c_c = parm_color_led_count;
  localparam int c_b = parm_basic_led_count;
  localparam int c_n = 3 * c_c + c_b;
  localparam int c_iw = $clog2(c_n + 1);
  localparam int c_tick_cycles = fn_tick_cycles(parm_FCLK, parm_step_period_microseconds);
  localparam logic [7:0] c_step = 8'(parm_step_size);
  localparam logic [c_iw-1:0] c_last = c_iw'(c_n - 1);
  localparam int c_red_base = fn_group_base(c_grp_red, c_c);
  localparam int c_green_base = fn_group_base(c_grp_green, c_c);
  localparam int c_blue_base = fn_group_base(c_grp_blue, c_c);
  localparam int c_basic_base = fn_group_base(c_grp_basic, c_c);
  // A scan plus its entry/exit must fit between ticks or ticks would pile up.
  if (c_tick_cycles <= c_n + 2) begin : g_bad_period
    $error("led_palette_fader: tick period %0d too short for %0d channels", c_tick_cycles, c_n);
  end
  t_fader_state r_state, w_state_nx;
  logic [c_iw-1:0] r_scan_idx;
  logic r_pending, r_changed, r_ready, r_error, r_settled;
  logic [7:0] r_tgt [c_n];
  logic [7:0] r_cur [c_n];
  logic w_tick, w_start, w_last, w_scan, w_accept, w_in_range, w_moved, w_clear_settled;
  logic [7:0] w_cur_sel, w_tgt_sel, w_cmd_cur, w_slewed;
  led_step_tick_gen #(.parm_cycles(c_tick_cycles)) u_tick (
    .i_clk  (i_clk),
    .i_arstn(i_arstn),
    .o_tick (w_tick)
  );
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  always_comb begin
    w_start = 1'b0;
    w_last = 1'b0;
    w_state_nx = r_state;
    if (r_state == ST_IDLE) begin
      w_start = w_tick || r_pending;
      w_state_nx = w_start ? ST_SCAN : ST_IDLE;
    end else begin
      w_last = r_scan_idx == c_last;
      w_state_nx = w_last ? ST_IDLE : ST_SCAN;
    end
  end
  always_comb begin
    w_cur_sel = '0;
    w_tgt_sel = '0;
    w_cmd_cur = '0;
    for (int j = 0; j < c_n; j++) begin
      if (r_scan_idx == c_iw'(j)) begin
        w_cur_sel = r_cur[j];
        w_tgt_sel = r_tgt[j];
      end
      if (i_cmd_index == c_iw'(j)) w_cmd_cur = r_cur[j];
    end
  end
  assign w_scan = r_state == ST_SCAN;
  assign w_slewed = fn_slew(w_cur_sel, w_tgt_sel, c_step);
  assign w_moved = w_scan && (w_slewed != w_cur_sel);
  // r_ready is only ever high in ST_IDLE, so it also gates accepts.
  assign w_accept = i_cmd_valid && r_ready;
  assign w_in_range = i_cmd_index < c_iw'(c_n);
  assign w_clear_settled = w_accept && w_in_range && !i_cmd_immediate && (i_cmd_target != w_cmd_cur);
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) begin
      r_scan_idx <= '0;
      r_pending <= 1'b0;
      r_changed <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_settled <= 1'b1;
      for (int j = 0; j < c_n; j++) begin
        r_tgt[j] <= '0;
        r_cur[j] <= '0;
      end
    end else begin
      r_ready <= w_state_nx == ST_IDLE;
      r_error <= w_accept && !w_in_range;
      r_pending <= (w_scan && w_tick) || (r_pending && !w_start);
      r_scan_idx <= w_start ? '0 : w_scan ? r_scan_idx + c_iw'(1) : r_scan_idx;
      r_changed <= w_start ? 1'b0 : r_changed || w_moved;
      r_settled <= w_last ? !(r_changed || w_moved) : w_clear_settled ? 1'b0 : r_settled;
      for (int j = 0; j < c_n; j++) begin
        if (w_accept && i_cmd_index == c_iw'(j)) begin
          r_tgt[j] <= i_cmd_target;
          if (i_cmd_immediate) r_cur[j] <= i_cmd_target;
        end
        if (w_scan && r_scan_idx == c_iw'(j)) r_cur[j] <= w_slewed;
      end
    end
  assign o_cmd_ready = r_ready;
  assign o_cmd_error = r_error;
  assign o_all_settled = r_settled;
  for (genvar g = 0; g < c_c; g++) begin : g_color
    assign o_color_led_red_value[8*g+7 -: 8] = r_cur[c_red_base+g];
    assign o_color_led_green_value[8*g+7 -: 8] = r_cur[c_green_base+g];
    assign o_color_led_blue_value[8*g+7 -: 8] = r_cur[c_blue_base+g];
  end
  for (genvar g = 0; g < c_b; g++) begin : g_basic
    assign o_basic_led_lumin_value[8*g+7 -: 8] = r_cur[c_basic_base+g];
  end
endmodule
